// File: rtl/qu_fetch_unit.sv
// Purpose: Qu instruction fetch sequencer; owns fetch PC, one outstanding imem request, small instruction buffer.
// Latency: request handshake at N, response at N+1, instruction on instr_* at N+2 (one instr per 2 cycles).
// Backpressure: no request issue while the buffer is full; decode drains the head with instr_valid/instr_ready.
module qu_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc
);

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  logic [1:0]    state, state_nxt;
  logic [31:0]   fetch_pc;
  logic [31:0]   req_pc;
  logic [31:0]   buf_data [BUF_DEPTH];
  logic [31:0]   buf_pc   [BUF_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic        req_fire;
  logic        rsp_take;
  logic        rsp_is_fence;
  logic        push, pop;
  logic [31:0] redirect_aligned;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(BUF_DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  // Masking keeps every redirect_pc bit in use while forcing word alignment.
  assign redirect_aligned = redirect_pc & ~32'h3;

  // Issue only from FETCH with a free slot; addr stays fetch_pc until accepted.
  assign imem_req_valid = !rst && (state == S_FETCH) && (count < CW'(BUF_DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_take     = (state == S_WAIT) && imem_rsp_valid;
  assign rsp_is_fence = (imem_rsp_data[6:0] == 7'b0001111) && (imem_rsp_data[14:12] == 3'b001);

  // A redirect flushes the buffer, so it cancels any same-cycle push or pop.
  assign instr_valid = (count != '0);
  assign push        = rsp_take && !redirect_valid;
  assign pop         = instr_valid && instr_ready && !redirect_valid;

  assign instr_data = instr_valid ? buf_data[rd_ptr] : '0;
  assign instr_pc   = instr_valid ? buf_pc[rd_ptr]   : '0;

  // Next-state selection; redirect overrides everything and drains any live request.
  always_comb begin
    state_nxt = state;
    if (redirect_valid) begin
      if (((state == S_WAIT) || (state == S_DRAIN)) && !imem_rsp_valid)
        state_nxt = S_DRAIN;
      else if (req_fire)
        state_nxt = S_DRAIN;
      else
        state_nxt = S_FETCH;
    end else begin
      case (state)
        S_FETCH: if (req_fire) state_nxt = S_WAIT;
        S_WAIT:  if (imem_rsp_valid) state_nxt = rsp_is_fence ? S_HALT : S_FETCH;
        S_DRAIN: if (imem_rsp_valid) state_nxt = S_FETCH;
        default: state_nxt = state;
      endcase
    end
  end

  // Control state: FSM, fetch PC, outstanding-request PC, buffer pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      state <= state_nxt;
      if (req_fire) req_pc <= fetch_pc;
      if (redirect_valid) begin
        fetch_pc <= redirect_aligned;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        if (push) wr_ptr <= ptr_inc(wr_ptr);
        if (pop)  rd_ptr <= ptr_inc(rd_ptr);
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // Buffer storage; contents are don't-care while unoccupied since outputs are gated.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      buf_data[wr_ptr] <= imem_rsp_data;
      buf_pc[wr_ptr]   <= req_pc;
    end
  end

endmodule

// File: tb/tb_qu_fetch_unit.sv
// Directed bench for qu_fetch_unit: memory, decode and execute are driven cycle by cycle.
// Inputs change 1 time unit after the rising edge; outputs are checked 2 units later.
// Expected PCs and instruction words are written by hand per step.
module tb_qu_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;

  int vectors = 0;
  int errs    = 0;

  qu_fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction word the bench's memory returns for an address (opcode 0x13, never fence.i).
  function automatic logic [31:0] dat(input logic [31:0] a);
    return {a[23:0], 8'h13};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rr, input logic rv, input logic [31:0] rd,
                       input logic ir, input logic dv, input logic [31:0] dp);
    imem_req_ready = rr;
    imem_rsp_valid = rv;
    imem_rsp_data  = rd;
    instr_ready    = ir;
    redirect_valid = dv;
    redirect_pc    = dp;
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_req(input string tag, input logic v, input logic [31:0] a);
    chk({tag, "_req_valid"}, {31'b0, imem_req_valid}, {31'b0, v});
    if (v) chk({tag, "_req_addr"}, imem_req_addr, a);
  endtask

  task automatic chk_ins(input string tag, input logic [31:0] pc, input logic [31:0] d);
    chk({tag, "_instr_valid"}, {31'b0, instr_valid}, 32'd1);
    chk({tag, "_instr_pc"}, instr_pc, pc);
    chk({tag, "_instr_data"}, instr_data, d);
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_instr_valid"}, {31'b0, instr_valid}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

    // Reset state
    tick(); tick();
    drive(0, 0, 0, 0, 0, 0);
    chk_req("rst", 0, 0);
    chk_empty("rst");
    chk("rst_instr_data", instr_data, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);

    // Streaming with ready memory and decode: 0x0, 0x4, 0x8 on alternate cycles
    tick(); rst = 1'b0;
    drive(1, 0, 0, 1, 0, 0);
    chk_req("t1_first", 1, 32'h0);
    chk_empty("t1_first");
    for (int k = 0; k < 3; k++) begin
      tick();
      drive(1, 1, dat(32'(4 * k)), 1, 0, 0);
      chk_req("t1_wait", 0, 0);
      chk_empty("t1_wait");
      tick();
      drive(1, 0, 0, 1, 0, 0);
      chk_ins("t1_deliver", 32'(4 * k), dat(32'(4 * k)));
      chk_req("t1_next", 1, 32'(4 * k + 4));
    end

    // Reset with a response arriving while rst is high
    tick(); rst = 1'b1;
    drive(0, 1, dat(32'hC), 0, 0, 0);
    chk_req("rst2_hold", 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk_req("rst2", 0, 0);
    chk_empty("rst2");
    chk("rst2_instr_data", instr_data, 32'h0);

    // Decode stalled: buffer fills with 0x0 and 0x4, issue stops
    tick(); rst = 1'b0;
    drive(1, 0, 0, 0, 0, 0);
    chk_req("t2_req0", 1, 32'h0);
    tick();
    drive(1, 1, dat(32'h0), 0, 0, 0);
    chk_req("t2_wait0", 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 0);
    chk_ins("t2_head0", 32'h0, dat(32'h0));
    chk_req("t2_req4", 1, 32'h4);
    tick();
    drive(1, 1, dat(32'h4), 0, 0, 0);
    chk_req("t2_wait4", 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 0);
    chk_req("t2_full_a", 0, 0);
    chk_ins("t2_full_head", 32'h0, dat(32'h0));
    tick();
    drive(0, 0, 0, 1, 0, 0);
    chk_req("t2_full_b", 0, 0);
    chk_ins("t2_pop0", 32'h0, dat(32'h0));

    // Memory stalls 3 cycles on 0x8 while decode drains 0x4
    tick();
    drive(0, 0, 0, 1, 0, 0);
    chk_ins("t2_pop4", 32'h4, dat(32'h4));
    chk_req("t3_stall1", 1, 32'h8);
    tick();
    drive(0, 0, 0, 1, 0, 0);
    chk_empty("t3_drained");
    chk_req("t3_stall2", 1, 32'h8);
    tick();
    drive(0, 0, 0, 1, 0, 0);
    chk_req("t3_stall3", 1, 32'h8);
    tick();
    drive(1, 0, 0, 1, 0, 0);
    chk_req("t3_accept", 1, 32'h8);

    // Redirect to 0x102 while waiting on 0x8: stale response dropped
    tick();
    drive(0, 0, 0, 1, 1, 32'h102);
    chk_req("t4_wait", 0, 0);
    tick();
    drive(1, 1, dat(32'h8), 1, 0, 0);
    chk_req("t4_drain", 0, 0);
    chk_empty("t4_drain");
    tick();
    drive(1, 0, 0, 1, 0, 0);
    chk_req("t4_new", 1, 32'h100);
    chk_empty("t4_stale_dropped");
    tick();
    drive(1, 1, dat(32'h100), 1, 0, 0);
    chk_empty("t4_wait100");
    tick();
    drive(1, 0, 0, 1, 0, 0);
    chk_ins("t4_deliver", 32'h100, dat(32'h100));
    chk_req("t4_req104", 1, 32'h104);

    // Redirect to 0x200 in the same cycle as the 0x104 response
    tick();
    drive(1, 1, dat(32'h104), 1, 1, 32'h200);
    chk_req("t5_wait", 0, 0);
    tick();
    drive(0, 0, 0, 1, 1, 32'hC);
    chk_req("t5_req200", 1, 32'h200);
    chk_empty("t5_dropped");

    // fence.i at 0xC halts issue until a redirect
    tick();
    drive(1, 0, 0, 1, 0, 0);
    chk_req("t6_reqC", 1, 32'hC);
    tick();
    drive(1, 1, 32'h0000_100F, 1, 0, 0);
    chk_req("t6_wait", 0, 0);
    tick();
    drive(1, 0, 0, 1, 0, 0);
    chk_ins("t6_fence", 32'hC, 32'h0000_100F);
    chk_req("t6_halt0", 0, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      drive(1, 0, 0, 1, 0, 0);
      chk_req("t6_halt", 0, 0);
    end
    tick();
    drive(1, 0, 0, 1, 1, 32'h10);
    chk_req("t6_halt_redir", 0, 0);
    tick();
    drive(1, 0, 0, 1, 1, 32'h40);
    chk_req("t6_req10", 1, 32'h10);

    // Redirect in the same cycle as a request handshake drains that request
    tick();
    drive(1, 1, dat(32'h10), 1, 0, 0);
    chk_req("t7_drain", 0, 0);
    chk_empty("t7_drain");
    tick();
    drive(0, 0, 0, 1, 1, 32'hFFFF_FFFF);
    chk_req("t7_req40", 1, 32'h40);
    chk_empty("t7_dropped");

    // Fetch PC wraps from 0xFFFF_FFFC to 0
    tick();
    drive(1, 0, 0, 1, 0, 0);
    chk_req("t8_reqtop", 1, 32'hFFFF_FFFC);
    tick();
    drive(1, 1, dat(32'hFFFF_FFFC), 1, 0, 0);
    chk_req("t8_wait", 0, 0);
    tick();
    drive(1, 0, 0, 1, 0, 0);
    chk_ins("t8_deliver", 32'hFFFF_FFFC, dat(32'hFFFF_FFFC));
    chk_req("t8_wrap", 1, 32'h0);

    // Reset mid-request with a response during reset: comes back in FETCH
    tick(); rst = 1'b1;
    drive(0, 1, dat(32'h0), 0, 0, 0);
    chk_req("t9_rst_hold", 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk_req("t9_rst", 0, 0);
    chk_empty("t9_rst");
    tick(); rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    chk_req("t9_after", 1, 32'h0);
    chk_empty("t9_after");
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk_req("t9_after2", 1, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
